// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package if_fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
   localparam logic [XLEN-1:0] ZERO_WORD        = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // RUN issues fetches; DRAIN swallows stale responses after a redirect
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   // One fetch-buffer entry: instruction address and returned word
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// In-order fetch buffer: slots are reserved at grant, filled at rvalid, popped by if_id.
module if_fifo
   import if_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     reserve_i,
   input  logic [XLEN-1:0]          reserve_addr_i,
   input  logic                     fill_i,
   input  logic [XLEN-1:0]          fill_data_i,
   input  logic                     pop_i,
   output logic                     head_filled_o,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fetch_entry_t     entry_q [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [PW-1:0]    rsv_ptr_q, rsv_ptr_d;
   logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
   logic [PW-1:0]    pop_ptr_q, pop_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointer, occupancy and filled-flag update; flush empties the buffer
   always_comb begin
      filled_d   = filled_q;
      rsv_ptr_d  = rsv_ptr_q;
      fill_ptr_d = fill_ptr_q;
      pop_ptr_d  = pop_ptr_q;
      count_d    = count_q;
      if (flush_i) begin
         filled_d   = '0;
         rsv_ptr_d  = '0;
         fill_ptr_d = '0;
         pop_ptr_d  = '0;
         count_d    = '0;
      end else begin
         if (pop_i) begin
            filled_d[pop_ptr_q] = 1'b0;
            pop_ptr_d           = pop_ptr_q + PW'(1);
         end
         if (reserve_i) begin
            filled_d[rsv_ptr_q] = 1'b0;
            rsv_ptr_d           = rsv_ptr_q + PW'(1);
         end
         if (fill_i) begin
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(reserve_i) - CW'(pop_i);
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         filled_q   <= '0;
         rsv_ptr_q  <= '0;
         fill_ptr_q <= '0;
         pop_ptr_q  <= '0;
         count_q    <= '0;
      end else begin
         filled_q   <= filled_d;
         rsv_ptr_q  <= rsv_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         pop_ptr_q  <= pop_ptr_d;
         count_q    <= count_d;
      end
   end

   // Payload storage; only meaningful while the matching filled flag is set
   always_ff @(posedge clk) begin
      if (reserve_i && !flush_i) begin
         entry_q[rsv_ptr_q].addr <= reserve_addr_i;
      end
      if (fill_i && !flush_i) begin
         entry_q[fill_ptr_q].data <= fill_data_i;
      end
   end

   assign head_filled_o = filled_q[pop_ptr_q];
   assign head_o        = entry_q[pop_ptr_q];
   assign count_o       = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, imem req/gnt/rvalid handshake, redirect draining, fetch buffer to if_id.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ready_i
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] in_flight_q, in_flight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic          active_q;

   logic          head_filled;
   fetch_entry_t  head;
   logic [CW-1:0] count;
   logic          pop_c, grant_c, rv_c, rv_drop_c, rv_fill_c;
   logic [CW-1:0] occ_c;

   // A pop this cycle frees a slot, so a full buffer can still issue and sustain one fetch per cycle
   assign pop_c      = head_filled & inst_ready_i;
   assign occ_c      = count - CW'(pop_c);
   assign imem_req_o = active_q & (state_q == ST_RUN) & (occ_c < CW'(BUF_DEPTH));
   assign imem_addr_o = pc_q;

   assign grant_c   = imem_req_o & imem_gnt_i;
   assign rv_c      = imem_rvalid_i & (in_flight_q != '0);
   assign rv_drop_c = rv_c & (discard_q != '0);
   assign rv_fill_c = rv_c & (discard_q == '0) & ~jump_en_i;

   // Next PC, outstanding/discard counters and RUN/DRAIN transitions; a jump overrides everything
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      discard_d   = discard_q;
      in_flight_d = in_flight_q + CW'(grant_c) - CW'(rv_c);
      if (jump_en_i) begin
         pc_d      = jump_addr_i & ~32'h3;
         discard_d = in_flight_d;
      end else begin
         if (grant_c) begin
            pc_d = pc_q + 32'd4;
         end
         if (rv_drop_c) begin
            discard_d = discard_q - CW'(1);
         end
      end
      case (state_q)
         ST_RUN:   if (discard_d != '0) state_d = ST_DRAIN;
         ST_DRAIN: if (discard_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // State registers; active_q keeps req low while reset is held
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         in_flight_q <= '0;
         discard_q   <= '0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         in_flight_q <= in_flight_d;
         discard_q   <= discard_d;
         active_q    <= 1'b1;
      end
   end

   if_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (jump_en_i),
      .reserve_i      (grant_c & ~jump_en_i),
      .reserve_addr_i (pc_q),
      .fill_i         (rv_fill_c),
      .fill_data_i    (imem_rdata_i),
      .pop_i          (pop_c & ~jump_en_i),
      .head_filled_o  (head_filled),
      .head_o         (head),
      .count_o        (count)
   );

   assign inst_valid_o = head_filled;
   assign inst_o       = head_filled ? head.data : INST_NOP;
   assign inst_addr_o  = head_filled ? head.addr : ZERO_WORD;

   // Buffered + in-flight equals reserved-or-filled slots plus words still to be discarded
   a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst)
      imem_rvalid_i |-> (in_flight_q != '0));
   a_capacity: assert property (@(posedge clk) disable iff (!rst)
      (32'(count) + 32'(discard_q)) <= 32'(BUF_DEPTH));

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: memory model, expected-stream queue, decoupled monitor.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i;

   int          vectors = 0;
   int          miscompares = 0;
   int unsigned gnt_pct = 0;
   int unsigned lat_extra = 0;
   int          cyc = 0;
   logic [31:0] next_addr;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   mreq_t mq[$];
   exp_t  exp_q[$];

   if_fetch #(
      .RESET_PC  (RST_PC),
      .BUF_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_ready_i  (inst_ready_i)
   );

   always #5 clk = ~clk;

   // Memory contents: a fixed bijective scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Instruction memory: random grants, in-order responses at least one cycle after grant
   always begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst) begin
         mq.delete();
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom();
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
         end
         imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
         #1;
         if (imem_rvalid_i) void'(mq.pop_front());
         if (imem_req_o && imem_gnt_i)
            mq.push_back('{addr: imem_addr_o, due: cyc + 1 + int'($urandom_range(0, lat_extra))});
      end
   end

   // Monitor: every transfer pops the scoreboard; idle outputs must show NOP / zero address
   always begin
      exp_t e;
      @(negedge clk);
      #3;
      if (rst) begin
         if (inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL xfer_unexpected: got addr %08h expected no transfer", inst_addr_o);
            end else begin
               e = exp_q.pop_front();
               chk("xfer_addr", inst_addr_o, e.addr);
               chk("xfer_data", inst_o, e.data);
            end
         end else if (!inst_valid_o) begin
            chk("idle_inst", inst_o, NOP);
            chk("idle_addr", inst_addr_o, 32'h0);
         end
         if (imem_req_o) chk("req_align", {30'd0, imem_addr_o[1:0]}, 32'h0);
      end
   end

   // Optionally redirect, then expect k sequential instructions and drive ready until all arrive
   task automatic run_seg(input logic do_jump, input logic [31:0] tgt, input int k,
                          input int unsigned rdy_pct, output int cycles);
      logic [31:0] a;
      a = next_addr;
      if (do_jump) begin
         @(negedge clk);
         jump_en_i    = 1'b1;
         jump_addr_i  = tgt;
         inst_ready_i = 1'b0;
         a            = tgt & ~32'h3;
      end
      for (int i = 0; i < k; i++) begin
         exp_q.push_back('{addr: a, data: mem_word(a)});
         a += 32'd4;
      end
      next_addr = a;
      cycles    = 0;
      while (cycles < 400) begin
         @(negedge clk);
         jump_en_i = 1'b0;
         if (exp_q.size() == 0) break;
         inst_ready_i = ($urandom_range(0, 99) < rdy_pct);
         cycles++;
      end
      inst_ready_i = 1'b0;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL seg_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] a;
      rst          = 1'b0;
      jump_en_i    = 1'b0;
      jump_addr_i  = '0;
      inst_ready_i = 1'b0;
      next_addr    = RST_PC;

      // Reset state
      repeat (2) @(negedge clk);
      #4;
      chk("rst_req",   32'(imem_req_o), 32'd0);
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_inst",  inst_o, NOP);
      chk("rst_addr",  inst_addr_o, 32'h0);

      // Release with no grants: request held at RESET_PC
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #4;
         chk("stall_req",  32'(imem_req_o), 32'd1);
         chk("stall_addr", imem_addr_o, RST_PC);
      end

      // Backpressure: two grants fill the buffer, request drops, head holds RESET_PC
      @(negedge clk);
      gnt_pct   = 100;
      lat_extra = 0;
      repeat (5) @(negedge clk);
      #4;
      chk("bp_req",   32'(imem_req_o), 32'd0);
      chk("bp_valid", 32'(inst_valid_o), 32'd1);
      chk("bp_addr",  inst_addr_o, RST_PC);
      chk("bp_data",  inst_o, mem_word(RST_PC));

      // Resume: nothing lost
      run_seg(1'b0, 32'h0, 10, 100, n);

      // Clean redirect with empty memory pipe: first output 3 cycles after jump, then 1 per cycle
      repeat (4) @(negedge clk);
      run_seg(1'b1, 32'h0000_0080, 8, 100, n);
      chk("thru_cycles", 32'(n), 32'd10);

      // Jump coinciding with grant and rvalid: one stale word drained, unaligned target rounded down
      repeat (4) @(negedge clk);
      run_seg(1'b1, 32'h0000_0400, 0, 100, n);
      run_seg(1'b1, 32'h0000_0203, 8, 100, n);
      chk("jgr_cycles", 32'(n), 32'd11);

      // PC wraps past 2^32
      gnt_pct   = 70;
      lat_extra = 2;
      run_seg(1'b1, 32'hFFFF_FFF6, 5, 70, n);

      // Random traffic
      for (int s = 0; s < 14; s++) begin
         gnt_pct   = $urandom_range(30, 100);
         lat_extra = $urandom_range(0, 2);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_seg(1'($urandom_range(0, 3) != 0), $urandom_range(0, 32'h0000_FFFF),
                 int'($urandom_range(1, 6)), $urandom_range(40, 100), n);
      end

      // Reset mid-stream: restart from RESET_PC
      gnt_pct   = 80;
      lat_extra = 1;
      a = next_addr;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back('{addr: a, data: mem_word(a)});
         a += 32'd4;
      end
      repeat (8) begin
         @(negedge clk);
         inst_ready_i = 1'b1;
      end
      @(negedge clk);
      rst          = 1'b0;
      inst_ready_i = 1'b0;
      exp_q.delete();
      #4;
      @(negedge clk);
      #4;
      chk("midrst_req",   32'(imem_req_o), 32'd0);
      chk("midrst_valid", 32'(inst_valid_o), 32'd0);
      @(negedge clk);
      rst       = 1'b1;
      next_addr = RST_PC;
      run_seg(1'b0, 32'h0, 6, 100, n);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
